// File: rtl/oven_pkg.sv
// Shared oven constants: 50 MHz timing values, repeat-FSM state encoding and button indices.
package oven_pkg;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_20MS = 1_000_000;
  localparam int REPEAT_500MS  = 25_000_000;
  localparam int REPEAT_100MS  = 5_000_000;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;
  localparam int BTN_D = 3;
  localparam int BTN_E = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rep_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, debounce, press/release pulses and optional
// auto-repeat (enabled by defining BTN_AUTOREPEAT_EN).
module btn_channel
  import oven_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_RATE     = REPEAT_100MS
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic released,
  output logic step
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX  = '1;

  logic              meta;
  logic              sync_q;
  logic              s;
  logic              stable;
  logic [DCNT_W-1:0] dcnt;
  logic              accept;

  // Synchronizer resets to the raw "released" level so no false press follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta   <= btn_n;
      sync_q <= meta;
    end
  end

  assign s      = ~sync_q;
  assign accept = (s != stable) && (dcnt == DCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= 1'b0;
      dcnt     <= '0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      if (s == stable) begin
        dcnt <= '0;
      end else if (accept) begin
        stable   <= s;
        dcnt     <= '0;
        press    <= s;
        released <= ~s;
      end else if (dcnt != DCNT_MAX) begin
        dcnt <= dcnt + DCNT_W'(1);
      end
    end
  end

  assign level = stable;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);
  localparam logic [RCNT_W-1:0] RCNT_MAX   = '1;

  rep_state_t        state;
  logic [RCNT_W-1:0] rcnt;
  logic              rise;
  logic              fall;

  assign rise = accept & s;
  assign fall = accept & ~s;

  // A release accepted on a due-repeat cycle takes priority, so that cycle has no step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            step  <= 1'b1;
            rcnt  <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (fall) begin
            rcnt  <= '0;
            state <= IDLE;
          end else if (rcnt == DELAY_LAST) begin
            step  <= 1'b1;
            rcnt  <= '0;
            state <= REPEAT;
          end else if (rcnt != RCNT_MAX) begin
            rcnt <= rcnt + RCNT_W'(1);
          end
        end
        REPEAT: begin
          if (fall) begin
            rcnt  <= '0;
            state <= IDLE;
          end else if (rcnt == RATE_LAST) begin
            step <= 1'b1;
            rcnt <= '0;
          end else if (rcnt != RCNT_MAX) begin
            rcnt <= rcnt + RCNT_W'(1);
          end
        end
        default: begin
          rcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
`else
  assign step = press;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN active-low pushbuttons into clean level/press/release/step signals.
// Auto-repeat stepping is built only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
  import oven_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_RATE     = REPEAT_100MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] released,
  output logic [N_BTN-1:0] step
);

  // Zero-length counts are meaningless; this block only exists for such configurations.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_unsupported_config
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
`endif
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_n[i]),
      .level   (level[i]),
      .press   (press[i]),
      .released(released[i]),
      .step    (step[i])
    );
  end

endmodule
